// File: rtl/hyper_mvblck_todram_multi.sv
// Drains COUNT_REQ words from one LSAB section and packs them into 2^BEATLOG-word MCU column writes.
// Handles unaligned starts, partial final groups, empty-section stalls with optional timeout, and early STOP.
module hyper_mvblck_todram_multi #(
  parameter int NSEC       = 4,
  parameter int SECW       = 2,
  parameter int AW         = 12,
  parameter int CW         = 6,
  parameter int BEATLOG    = 1,
  parameter int WAIT_LIMIT = 16
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NSEC-1:0]             LSAB_INT,
  input  logic [NSEC-1:0]             LSAB_STOP,
  input  logic [NSEC-1:0]             LSAB_EMPTY,
  input  logic [3*NSEC-1:0]           LSAB_ANCILL,
  output logic                        LSAB_READ,
  output logic [SECW-1:0]             LSAB_SECTION,
  input  logic [AW-1:0]               START_ADDRESS,
  input  logic [CW-1:0]               COUNT_REQ,
  input  logic [SECW-1:0]             SECTION,
  input  logic [1:0]                  DRAM_SEL,
  input  logic                        ISSUE,
  output logic [CW-1:0]               COUNT_SENT,
  output logic                        WORKING,
  output logic                        IRQ_OUT,
  output logic                        ABRUPT_STOP,
  output logic                        TIMEOUT,
  output logic [2:0]                  ANCILL_OUT,
  output logic [AW-1:0]               MCU_COLL_ADDRESS,
  output logic [2*(1<<BEATLOG)-1:0]   MCU_WE_ARRAY,
  output logic [1:0]                  MCU_REQUEST_ACCESS
);

  localparam int LANES = 1 << BEATLOG;
  localparam int WEW   = 2 * LANES;
  localparam int SW    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, XFER, FLUSH, DONE} state_t;

  state_t            state_q, state_d;
  logic [SECW-1:0]   sel_q;
  logic [AW-1:0]     track_addr_q;
  logic [CW-1:0]     len_left_q;
  logic [CW-1:0]     req_q;
  logic [1:0]        dsel_q;
  logic [WEW-1:0]    mask_q;
  logic [SW-1:0]     stall_q;
  logic              tmo_q;
  logic              busy_q;
  logic              working_q;
  logic [AW-1:0]     coll_addr_q;
  logic [WEW-1:0]    we_q;
  logic [1:0]        req_acc_q;
  logic [CW-1:0]     count_sent_q;
  logic              irq_q;
  logic              abrupt_q;
  logic              timeout_q;
  logic [2:0]        ancill_q;

  logic              sec_stop, sec_empty;
  logic              beat, stall, stall_hit, top_lane;
  logic [BEATLOG-1:0] lane;
  logic [WEW-1:0]    mask_new;
  logic [AW-1:0]     group_base;

  assign sec_stop   = LSAB_STOP[sel_q];
  assign sec_empty  = LSAB_EMPTY[sel_q];
  assign lane       = track_addr_q[BEATLOG-1:0];
  assign top_lane   = (lane == BEATLOG'(LANES - 1));
  assign mask_new   = mask_q | ({{(WEW-2){1'b0}}, 2'b11} << {lane, 1'b0});
  assign group_base = {track_addr_q[AW-1:BEATLOG], {BEATLOG{1'b0}}};

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (ISSUE) state_d = XFER;
      XFER:  if ((len_left_q == '0) || sec_stop || stall_hit) state_d = FLUSH;
      FLUSH: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // STOP outranks EMPTY: a stopped section neither beats nor counts as stalled.
  always_comb begin
    beat      = 1'b0;
    stall     = 1'b0;
    stall_hit = 1'b0;
    if (RST && (state_q == XFER) && (len_left_q != '0) && !sec_stop) begin
      beat      = !sec_empty;
      stall     = sec_empty;
      stall_hit = sec_empty && (WAIT_LIMIT != 0) && ((int'(stall_q) + 1) == WAIT_LIMIT);
    end
  end

  assign LSAB_READ = beat;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sel_q        <= '0;
      track_addr_q <= '0;
      len_left_q   <= '0;
      req_q        <= '0;
      dsel_q       <= '0;
      mask_q       <= '0;
      stall_q      <= '0;
      tmo_q        <= 1'b0;
      busy_q       <= 1'b0;
      working_q    <= 1'b0;
      coll_addr_q  <= '0;
      we_q         <= '0;
      req_acc_q    <= '0;
      count_sent_q <= '0;
      irq_q        <= 1'b0;
      abrupt_q     <= 1'b0;
      timeout_q    <= 1'b0;
      ancill_q     <= '0;
    end else begin
      req_acc_q <= '0;
      busy_q    <= (state_q != IDLE);
      working_q <= busy_q;
      case (state_q)
        IDLE: begin
          if (ISSUE) begin
            sel_q        <= SECTION;
            track_addr_q <= START_ADDRESS;
            len_left_q   <= COUNT_REQ;
            req_q        <= COUNT_REQ;
            dsel_q       <= DRAM_SEL;
            mask_q       <= '0;
            stall_q      <= '0;
            tmo_q        <= 1'b0;
          end
        end
        XFER: begin
          if (beat) begin
            track_addr_q <= track_addr_q + AW'(1);
            len_left_q   <= len_left_q - CW'(1);
            stall_q      <= '0;
            if (top_lane) begin
              coll_addr_q <= group_base;
              we_q        <= mask_new;
              req_acc_q   <= dsel_q;
              mask_q      <= '0;
            end else begin
              mask_q <= mask_new;
            end
          end else if (stall) begin
            stall_q <= stall_q + SW'(1);
            if (stall_hit) tmo_q <= 1'b1;
          end
        end
        // A nonzero mask never reached its top lane, so track_addr is still in that group.
        FLUSH: begin
          if (mask_q != '0) begin
            coll_addr_q <= group_base;
            we_q        <= mask_q;
            req_acc_q   <= dsel_q;
            mask_q      <= '0;
          end
        end
        DONE: begin
          count_sent_q <= req_q - len_left_q;
          abrupt_q     <= (len_left_q != '0);
          timeout_q    <= tmo_q;
          irq_q        <= LSAB_INT[sel_q];
          ancill_q     <= LSAB_ANCILL[3*sel_q +: 3];
        end
        default: ;
      endcase
    end
  end

  assign LSAB_SECTION       = sel_q;
  assign COUNT_SENT         = count_sent_q;
  assign WORKING            = working_q;
  assign IRQ_OUT            = irq_q;
  assign ABRUPT_STOP        = abrupt_q;
  assign TIMEOUT            = timeout_q;
  assign ANCILL_OUT         = ancill_q;
  assign MCU_COLL_ADDRESS   = coll_addr_q;
  assign MCU_WE_ARRAY       = we_q;
  assign MCU_REQUEST_ACCESS = req_acc_q;

endmodule

// File: tb/tb_hyper_mvblck_todram_multi.sv
// Directed bench for the LSAB-to-DRAM mover: logs reads and MCU requests, checks against hand-computed vectors.
module tb_hyper_mvblck_todram_multi;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  LSAB_INT, LSAB_STOP, LSAB_EMPTY;
  logic [11:0] LSAB_ANCILL;
  logic        LSAB_READ;
  logic [1:0]  LSAB_SECTION;
  logic [11:0] START_ADDRESS;
  logic [5:0]  COUNT_REQ;
  logic [1:0]  SECTION, DRAM_SEL;
  logic        ISSUE;
  logic [5:0]  COUNT_SENT;
  logic        WORKING, IRQ_OUT, ABRUPT_STOP, TIMEOUT;
  logic [2:0]  ANCILL_OUT;
  logic [11:0] MCU_COLL_ADDRESS;
  logic [3:0]  MCU_WE_ARRAY;
  logic [1:0]  MCU_REQUEST_ACCESS;

  hyper_mvblck_todram_multi dut (
    .CLK(CLK), .RST(RST), .LSAB_INT(LSAB_INT), .LSAB_STOP(LSAB_STOP),
    .LSAB_EMPTY(LSAB_EMPTY), .LSAB_ANCILL(LSAB_ANCILL), .LSAB_READ(LSAB_READ),
    .LSAB_SECTION(LSAB_SECTION), .START_ADDRESS(START_ADDRESS), .COUNT_REQ(COUNT_REQ),
    .SECTION(SECTION), .DRAM_SEL(DRAM_SEL), .ISSUE(ISSUE), .COUNT_SENT(COUNT_SENT),
    .WORKING(WORKING), .IRQ_OUT(IRQ_OUT), .ABRUPT_STOP(ABRUPT_STOP), .TIMEOUT(TIMEOUT),
    .ANCILL_OUT(ANCILL_OUT), .MCU_COLL_ADDRESS(MCU_COLL_ADDRESS),
    .MCU_WE_ARRAY(MCU_WE_ARRAY), .MCU_REQUEST_ACCESS(MCU_REQUEST_ACCESS)
  );

  always #5 CLK = ~CLK;

  int          errors = 0;
  int          checks = 0;
  int          reads  = 0;
  logic [17:0] reqs[$];

  always @(negedge CLK) begin
    if (LSAB_READ) reads++;
    if (MCU_REQUEST_ACCESS != 2'b00) reqs.push_back({MCU_REQUEST_ACCESS, MCU_WE_ARRAY, MCU_COLL_ADDRESS});
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [17:0] rq(input logic [1:0] p, input logic [3:0] w, input logic [11:0] a);
    return {p, w, a};
  endfunction

  task automatic exp_req(input string tag, input int idx, input logic [17:0] e);
    logic [17:0] v;
    v = (idx < reqs.size()) ? reqs[idx] : 18'h3FFFF;
    check(tag, 32'(v), 32'(e));
  endtask

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic start_job(input logic [1:0] sec, input logic [11:0] addr,
                           input logic [5:0] cnt, input logic [1:0] dsel);
    SECTION = sec; START_ADDRESS = addr; COUNT_REQ = cnt; DRAM_SEL = dsel;
    reads = 0;
    reqs.delete();
    ISSUE = 1'b1;
    tick();
    ISSUE = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!WORKING && n < 100) begin tick(); n++; end
    while (WORKING && n < 400) begin tick(); n++; end
    check("job_end_budget", 32'(WORKING), 0);
  endtask

  task automatic wait_reads(input int target);
    int n = 0;
    while (reads < target && n < 100) begin tick(); n++; end
    check("reads_budget", 32'(reads >= target), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    RST = 1'b0; ISSUE = 1'b0;
    LSAB_INT = 4'b0010; LSAB_STOP = '0; LSAB_EMPTY = '0;
    LSAB_ANCILL = {3'b000, 3'b000, 3'b101, 3'b010};
    START_ADDRESS = '0; COUNT_REQ = '0; SECTION = '0; DRAM_SEL = '0;
    repeat (3) tick();
    check("rst_count_sent", 32'(COUNT_SENT), 0);
    check("rst_working", 32'(WORKING), 0);
    check("rst_req", 32'(MCU_REQUEST_ACCESS), 0);
    check("rst_read", 32'(LSAB_READ), 0);
    RST = 1'b1;
    tick();

    // aligned full transfer, also WORKING latency
    start_job(2'd2, 12'h010, 6'd6, 2'd2);
    check("working_c1", 32'(WORKING), 0);
    tick();
    check("working_c2", 32'(WORKING), 0);
    tick();
    check("working_c3", 32'(WORKING), 1);
    wait_done();
    check("al_reads", reads, 6);
    check("al_nreq", reqs.size(), 3);
    exp_req("al_req0", 0, rq(2'd2, 4'b1111, 12'h010));
    exp_req("al_req1", 1, rq(2'd2, 4'b1111, 12'h012));
    exp_req("al_req2", 2, rq(2'd2, 4'b1111, 12'h014));
    check("al_sent", 32'(COUNT_SENT), 6);
    check("al_abrupt", 32'(ABRUPT_STOP), 0);
    check("al_timeout", 32'(TIMEOUT), 0);
    check("al_section", 32'(LSAB_SECTION), 2);

    // unaligned start
    start_job(2'd0, 12'h011, 6'd3, 2'd1);
    wait_done();
    check("ua_nreq", reqs.size(), 2);
    exp_req("ua_req0", 0, rq(2'd1, 4'b1100, 12'h010));
    exp_req("ua_req1", 1, rq(2'd1, 4'b1111, 12'h012));
    check("ua_sent", 32'(COUNT_SENT), 3);

    // early stop after three beats
    start_job(2'd1, 12'h020, 6'd8, 2'd3);
    wait_reads(3);
    LSAB_STOP[1] = 1'b1;
    wait_done();
    LSAB_STOP[1] = 1'b0;
    check("st_reads", reads, 3);
    check("st_nreq", reqs.size(), 2);
    exp_req("st_req0", 0, rq(2'd3, 4'b1111, 12'h020));
    exp_req("st_req1", 1, rq(2'd3, 4'b0011, 12'h022));
    check("st_sent", 32'(COUNT_SENT), 3);
    check("st_abrupt", 32'(ABRUPT_STOP), 1);
    check("st_irq", 32'(IRQ_OUT), 1);
    check("st_ancill", 32'(ANCILL_OUT), 3'b101);

    // empty for five cycles, then data
    LSAB_EMPTY[0] = 1'b1;
    start_job(2'd0, 12'h040, 6'd4, 2'd2);
    repeat (5) @(negedge CLK);
    check("em_no_read", reads, 0);
    tick();
    LSAB_EMPTY[0] = 1'b0;
    wait_done();
    check("em_reads", reads, 4);
    exp_req("em_req0", 0, rq(2'd2, 4'b1111, 12'h040));
    exp_req("em_req1", 1, rq(2'd2, 4'b1111, 12'h042));
    check("em_sent", 32'(COUNT_SENT), 4);
    check("em_timeout", 32'(TIMEOUT), 0);
    check("em_irq", 32'(IRQ_OUT), 0);

    // empty held: stall timeout
    LSAB_EMPTY[0] = 1'b1;
    start_job(2'd0, 12'h040, 6'd4, 2'd2);
    wait_done();
    LSAB_EMPTY[0] = 1'b0;
    check("to_timeout", 32'(TIMEOUT), 1);
    check("to_abrupt", 32'(ABRUPT_STOP), 1);
    check("to_sent", 32'(COUNT_SENT), 0);
    check("to_nreq", reqs.size(), 0);
    check("to_reads", reads, 0);

    // zero-length job
    start_job(2'd1, 12'h033, 6'd0, 2'd1);
    wait_done();
    check("z_reads", reads, 0);
    check("z_nreq", reqs.size(), 0);
    check("z_sent", 32'(COUNT_SENT), 0);
    check("z_abrupt", 32'(ABRUPT_STOP), 0);
    check("z_timeout", 32'(TIMEOUT), 0);

    // address wrap
    start_job(2'd0, 12'hFFF, 6'd2, 2'd1);
    wait_done();
    check("wr_nreq", reqs.size(), 2);
    exp_req("wr_req0", 0, rq(2'd1, 4'b1100, 12'hFFE));
    exp_req("wr_req1", 1, rq(2'd1, 4'b0011, 12'h000));
    check("wr_sent", 32'(COUNT_SENT), 2);
    check("wr_ancill", 32'(ANCILL_OUT), 3'b010);

    // reset mid-job
    start_job(2'd2, 12'h030, 6'd6, 2'd1);
    wait_reads(2);
    RST = 1'b0;
    @(negedge CLK);
    check("mr_read_in_rst", 32'(LSAB_READ), 0);
    tick();
    check("mr_sent", 32'(COUNT_SENT), 0);
    check("mr_req", 32'(MCU_REQUEST_ACCESS), 0);
    check("mr_we", 32'(MCU_WE_ARRAY), 0);
    check("mr_addr", 32'(MCU_COLL_ADDRESS), 0);
    check("mr_ancill", 32'(ANCILL_OUT), 0);
    check("mr_section", 32'(LSAB_SECTION), 0);
    RST = 1'b1;
    reads = 0;
    reqs.delete();
    repeat (6) tick();
    check("mr_idle_reads", reads, 0);
    check("mr_idle_nreq", reqs.size(), 0);
    check("mr_idle_working", 32'(WORKING), 0);

    // new job runs; ISSUE during XFER ignored
    LSAB_EMPTY[3] = 1'b1;
    start_job(2'd3, 12'h050, 6'd4, 2'd3);
    SECTION = 2'd0; START_ADDRESS = 12'h100; COUNT_REQ = 6'd1; DRAM_SEL = 2'd1;
    ISSUE = 1'b1;
    tick();
    ISSUE = 1'b0;
    repeat (3) tick();
    LSAB_EMPTY[3] = 1'b0;
    wait_done();
    check("ni_section", 32'(LSAB_SECTION), 3);
    check("ni_sent", 32'(COUNT_SENT), 4);
    check("ni_nreq", reqs.size(), 2);
    exp_req("ni_req0", 0, rq(2'd3, 4'b1111, 12'h050));
    exp_req("ni_req1", 1, rq(2'd3, 4'b1111, 12'h052));
    repeat (6) tick();
    check("ni_no_second_job", 32'(WORKING), 0);
    check("ni_no_extra_reads", reads, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
